tm_feedback_gen: RTL

Training-side feedback generator for one Tsetlin Machine class. It is the reverse path of the sum-and-threshold decision logic. It takes the same positive/negative clause output vectors plus the target label, and computes the clamped vote. It then walks all clauses in order and issues one per-clause feedback command (none / Type I / Type II) to the automata update logic over a valid/ready handshake. Randomised clause selection comes from an internal LFSR.

---
 rtl/tm_feedback_gen.sv | 114 +++++++++++
 1 files changed

// File: rtl/tm_feedback_gen.sv
// tm_feedback_gen: per-clause Tsetlin feedback command generator with LFSR-driven selection
module tm_feedback_gen #(
  parameter int          NCLAUSE = 10,
  parameter int          T       = 5,
  parameter logic [15:0] SEED    = 16'hACE1,
  localparam int         IW      = $clog2(NCLAUSE)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [NCLAUSE-1:0] pos_clause,
  input  logic [NCLAUSE-1:0] neg_clause,
  input  logic               label,
  output logic               fb_valid,
  input  logic               fb_ready,
  output logic [IW-1:0]      fb_index,
  output logic               fb_polarity,
  output logic [1:0]         fb_type,
  output logic               busy,
  output logic               done
);
  localparam int VW = $clog2(NCLAUSE + 1) + 2;
  localparam int SW = VW + 9;
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_CALC  = 2'd1;
  localparam logic [1:0] S_ISSUE = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;
  localparam logic signed [VW-1:0] TS = VW'(T);
  localparam logic [SW-1:0] T2 = SW'(2 * T);
  localparam logic [IW-1:0] LAST = IW'(NCLAUSE - 1);

  logic [1:0]         r_state;
  logic [NCLAUSE-1:0] r_pos, r_neg;
  logic               r_label;
  logic [VW-1:0]      r_num;
  logic [15:0]        r_lfsr;
  logic               r_fb_valid;
  logic [IW-1:0]      r_idx;
  logic               r_pol;
  logic [VW-1:0]        w_pcp, w_pcn, w_num;
  logic signed [VW-1:0] w_v, w_vc;
  logic                 w_sel, w_xfer, w_last;
  logic [15:0]          w_lfsr_next;

  // popcount of the latched clause vectors, each bit counted once
  always_comb begin
    w_pcp = '0;
    w_pcn = '0;
    for (int i = 0; i < NCLAUSE; i++) begin
      w_pcp = w_pcp + VW'(r_pos[i]);
      w_pcn = w_pcn + VW'(r_neg[i]);
    end
  end

  assign w_v  = $signed(w_pcp) - $signed(w_pcn);
  assign w_vc = w_v > TS ? TS : (w_v < -TS ? -TS : w_v);
  assign w_num = r_label ? TS - w_vc : TS + w_vc;

  assign w_sel       = (SW'(r_lfsr[7:0]) * T2) < (SW'(r_num) << 8);
  assign w_xfer      = r_fb_valid && fb_ready;
  assign w_last      = r_pol && r_idx == LAST;
  assign w_lfsr_next = (r_lfsr >> 1) ^ (r_lfsr[0] ? 16'hB400 : 16'h0000);

  assign in_ready    = r_state == S_IDLE;
  assign busy        = r_state != S_IDLE;
  assign done        = r_state == S_DONE;
  assign fb_valid    = r_fb_valid;
  assign fb_index    = r_idx;
  assign fb_polarity = r_pol;
  assign fb_type     = !r_fb_valid || !w_sel ? 2'b00 : (r_pol ^ r_label) ? 2'b01 : 2'b10;

  // job sequencing, clause cursor and LFSR; lfsr steps once per accepted command
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_pos      <= '0;
      r_neg      <= '0;
      r_label    <= 1'b0;
      r_num      <= '0;
      r_lfsr     <= SEED;
      r_fb_valid <= 1'b0;
      r_idx      <= '0;
      r_pol      <= 1'b0;
    end else begin
      if (w_xfer) r_lfsr <= w_lfsr_next;
      case (r_state)
        S_IDLE: if (in_valid) begin
          r_pos   <= pos_clause;
          r_neg   <= neg_clause;
          r_label <= label;
          r_state <= S_CALC;
        end
        S_CALC: begin
          r_num      <= w_num;
          r_idx      <= '0;
          r_pol      <= 1'b0;
          r_fb_valid <= 1'b1;
          r_state    <= S_ISSUE;
        end
        S_ISSUE: if (w_xfer) begin
          r_idx <= r_idx == LAST ? '0 : r_idx + 1'b1;
          r_pol <= r_idx == LAST ? 1'b1 : r_pol;
          if (w_last) begin
            r_fb_valid <= 1'b0;
            r_pol      <= 1'b0;
            r_state    <= S_DONE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule
